graph_data_buffer: RTL and testbench

- Double-buffered (ping-pong) bin store. Replaces the static graph ROM feeding graph_renderer, which makes live FFT display possible.
- Accepts a stream of FFT magnitude bins over a valid/ready handshake and scales each to a pixel height.
- Fills the back bank while the renderer reads the front bank.
- Swaps banks only at the vsync falling edge, and only after a complete frame, so the display never tears.

---
 rtl/graph_pkg.sv | 17 +
 rtl/graph_bank_ram.sv | 30 +++
 rtl/graph_data_buffer.sv | 157 +++++++++++++++
 tb/tb_graph_data_buffer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// Shared constants for the spectrum graph path: bin geometry, height scaling
// and the write-FSM state encoding used by graph_data_buffer.
package graph_pkg;

    localparam int N_BINS     = 256;
    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 9;
    localparam int SHIFT      = 7;
    localparam int MAX_HEIGHT = 479;

    typedef logic [1:0] state_t;

    localparam state_t ST_FILL      = 2'd0;
    localparam state_t ST_DISCARD   = 2'd1;
    localparam state_t ST_WAIT_SWAP = 2'd2;

endpackage

// File: rtl/graph_bank_ram.sv
// One bank of the ping-pong store: simple dual-port RAM with a synchronous
// write port and a registered read port, shaped to infer a block RAM.
module graph_bank_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 9
) (
    input  logic              clk_pixel,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: no reset on the array or its read register; a reset would stop
    // block-RAM inference, and the consumer masks stale data itself.
    always_ff @(posedge clk_pixel) begin
        if (we_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/graph_data_buffer.sv
// Ping-pong bin store between the FFT magnitude stream and graph_renderer;
// the back bank fills while the front bank is displayed, swapping on vsync fall.
module graph_data_buffer #(
    parameter int N_BINS     = graph_pkg::N_BINS,
    parameter int ADDR_W     = graph_pkg::ADDR_W,
    parameter int IN_W       = 16,
    parameter int DATA_W     = graph_pkg::DATA_W,
    parameter int SHIFT      = graph_pkg::SHIFT,
    parameter int MAX_HEIGHT = graph_pkg::MAX_HEIGHT
) (
    input  logic              clk_pixel,
    input  logic              rst_sync_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
    input  logic              s_last,
    input  logic              vsync,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              front_sel,
    output logic              frame_swapped,
    output logic              frame_dropped
);

    import graph_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(N_BINS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              front_sel_q, front_sel_d;
    logic              have_frame_q, have_frame_d;
    logic              swapped_q, swapped_d;
    logic              dropped_q, dropped_d;
    logic              vsync_q;
    logic              ready_en_q;
    logic              rd_sel_q;
    logic              rd_have_q;

    logic              accept;
    logic              vsync_fall;
    logic              wr_en;
    logic [IN_W-1:0]   mag_shifted;
    logic [DATA_W-1:0] height;
    logic [DATA_W-1:0] bank0_rd, bank1_rd;

    assign s_ready    = ready_en_q && (state_q != ST_WAIT_SWAP);
    assign accept     = s_valid && s_ready;
    assign vsync_fall = vsync_q && !vsync;

    // Saturation compare is done at full input width so large magnitudes
    // cannot wrap into a small height.
    assign mag_shifted = s_data >> SHIFT;
    assign height      = (mag_shifted > IN_W'(MAX_HEIGHT)) ? DATA_W'(MAX_HEIGHT)
                                                           : mag_shifted[DATA_W-1:0];

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        front_sel_d  = front_sel_q;
        have_frame_d = have_frame_q;
        swapped_d    = 1'b0;
        dropped_d    = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    if (s_last && wr_ptr_q == LAST_PTR) begin
                        state_d = ST_WAIT_SWAP;
                    end else if (s_last) begin
                        dropped_d = 1'b1;
                        wr_ptr_d  = '0;
                    end else if (wr_ptr_q == LAST_PTR) begin
                        dropped_d = 1'b1;
                        state_d   = ST_DISCARD;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            ST_DISCARD: begin
                if (accept && s_last) begin
                    wr_ptr_d = '0;
                    state_d  = ST_FILL;
                end
            end
            ST_WAIT_SWAP: begin
                if (vsync_fall) begin
                    front_sel_d  = !front_sel_q;
                    have_frame_d = 1'b1;
                    swapped_d    = 1'b1;
                    wr_ptr_d     = '0;
                    state_d      = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_pixel or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            front_sel_q  <= 1'b0;
            have_frame_q <= 1'b0;
            swapped_q    <= 1'b0;
            dropped_q    <= 1'b0;
            vsync_q      <= 1'b1;
            ready_en_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_have_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            front_sel_q  <= front_sel_d;
            have_frame_q <= have_frame_d;
            swapped_q    <= swapped_d;
            dropped_q    <= dropped_d;
            vsync_q      <= vsync;
            ready_en_q   <= 1'b1;
            rd_sel_q     <= front_sel_q;
            rd_have_q    <= have_frame_q;
        end
    end

    // Writes always target the back bank, so reads never collide with them.
    assign wr_en = accept && (state_q == ST_FILL);

    graph_bank_ram #(.DEPTH(N_BINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank0 (
        .clk_pixel (clk_pixel),
        .we_i      (wr_en && front_sel_q),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (height),
        .rd_addr_i (rd_addr),
        .rd_data_o (bank0_rd)
    );

    graph_bank_ram #(.DEPTH(N_BINS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_bank1 (
        .clk_pixel (clk_pixel),
        .we_i      (wr_en && !front_sel_q),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (height),
        .rd_addr_i (rd_addr),
        .rd_data_o (bank1_rd)
    );

    // Bank select and frame-valid are delayed alongside the RAM read register,
    // so the swap-cycle read still comes from the pre-edge front bank.
    assign rd_data       = rd_have_q ? (rd_sel_q ? bank1_rd : bank0_rd) : '0;
    assign front_sel     = front_sel_q;
    assign frame_swapped = swapped_q;
    assign frame_dropped = dropped_q;

endmodule

// File: tb/tb_graph_data_buffer.sv
// Directed self-checking bench for graph_data_buffer: fills, swaps, saturation,
// short/long frame discard, vsync coincidence and mid-frame reset.
module tb_graph_data_buffer;

    logic        clk_pixel = 1'b0;
    logic        rst_sync_n;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        s_last;
    logic        vsync;
    logic [7:0]  rd_addr;
    logic [8:0]  rd_data;
    logic        front_sel;
    logic        frame_swapped;
    logic        frame_dropped;

    int vectors     = 0;
    int miscompares = 0;
    int swap_cnt    = 0;
    int drop_cnt    = 0;
    int acc_cnt     = 0;
    int drop_at     = -1;
    int wait_cycles = 0;

    logic [15:0] bnd_tab [5] = '{16'hEF00, 16'hEF80, 16'hF000, 16'hEFFF, 16'h007F};

    graph_data_buffer dut (
        .clk_pixel     (clk_pixel),
        .rst_sync_n    (rst_sync_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .vsync         (vsync),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .front_sel     (front_sel),
        .frame_swapped (frame_swapped),
        .frame_dropped (frame_dropped)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Pulse and acceptance monitor, sampling mid-cycle after the bench drives.
    always begin
        @(negedge clk_pixel);
        #3;
        if (frame_swapped) swap_cnt++;
        if (frame_dropped) begin
            drop_cnt++;
            drop_at = acc_cnt;
        end
        if (s_valid && s_ready) acc_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_pixel);
        #2;
    endtask

    function automatic logic [15:0] gen(input int mode, input int i);
        case (mode)
            0:       return 16'(i << 7);
            1:       return 16'hFFFF;
            2:       return 16'h0080;
            default: return bnd_tab[i % 5];
        endcase
    endfunction

    function automatic int exp_h(input logic [15:0] d);
        int v;
        v = int'(d) >> 7;
        return (v > 479) ? 479 : v;
    endfunction

    task automatic beat(input logic [15:0] d, input logic last, input logic vfall);
        int w;
        w = 0;
        while (!s_ready && w < 200) begin
            step();
            w++;
            wait_cycles++;
        end
        if (!s_ready) begin
            check("ready_timeout", 0, 1);
        end else begin
            s_valid = 1'b1;
            s_data  = d;
            s_last  = last;
            if (vfall) vsync = 1'b0;
            step();
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic send_frame(input int mode, input int nbeats, input int last_idx,
                              input logic coincide);
        for (int i = 0; i < nbeats; i++) begin
            beat(gen(mode, i), i == last_idx, coincide && (i == last_idx));
        end
    endtask

    task automatic vsync_fall();
        vsync = 1'b0;
        repeat (3) step();
        vsync = 1'b1;
        repeat (2) step();
    endtask

    task automatic rd(input string tag, input int addr, input int exp);
        rd_addr = 8'(addr);
        step();
        check(tag, int'(rd_data), exp);
    endtask

    initial begin
        int s0, d0, a0, w0;
        rst_sync_n = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        vsync      = 1'b1;
        rd_addr    = '0;

        // 1: reset state and release
        repeat (3) step();
        check("rst_ready", int'(s_ready), 0);
        check("rst_front", int'(front_sel), 0);
        check("rst_rd", int'(rd_data), 0);
        rst_sync_n = 1'b1;
        step();
        check("rel_ready", int'(s_ready), 1);
        rd("rel_rd37", 37, 0);
        step();
        check("rel_swaps", swap_cnt, 0);
        check("rel_drops", drop_cnt, 0);

        // 2: ramp frame, wait for vsync, swap
        send_frame(0, 256, 255, 1'b0);
        check("ramp_ready_lo", int'(s_ready), 0);
        repeat (5) step();
        check("ramp_ready_hold", int'(s_ready), 0);
        check("ramp_front_pre", int'(front_sel), 0);
        s0 = swap_cnt;
        vsync_fall();
        check("ramp_swap", swap_cnt - s0, 1);
        check("ramp_front", int'(front_sel), 1);
        check("ramp_ready_hi", int'(s_ready), 1);
        rd("ramp_rd10", 10, 10);
        rd("ramp_rd0", 0, 0);
        rd("ramp_rd255", 255, 255);

        // 3: saturation, unit height and height boundaries
        send_frame(1, 256, 255, 1'b0);
        vsync_fall();
        check("sat_front", int'(front_sel), 0);
        for (int a = 0; a < 256; a++) rd("sat_rd", a, 479);
        send_frame(2, 256, 255, 1'b0);
        vsync_fall();
        check("one_front", int'(front_sel), 1);
        for (int a = 0; a < 256; a++) rd("one_rd", a, 1);
        send_frame(4, 256, 255, 1'b0);
        vsync_fall();
        check("bnd_front", int'(front_sel), 0);
        for (int a = 0; a < 5; a++) rd("bnd_rd", a, exp_h(gen(4, a)));
        rd("bnd_rd478", 0, 478);
        rd("bnd_rdzero", 4, 0);

        // 4: short frame dropped, no swap, then good frame
        d0 = drop_cnt;
        s0 = swap_cnt;
        send_frame(2, 101, 100, 1'b0);
        step();
        check("short_drop", drop_cnt - d0, 1);
        check("short_ready", int'(s_ready), 1);
        vsync_fall();
        check("short_noswap", swap_cnt - s0, 0);
        check("short_front", int'(front_sel), 0);
        rd("short_rd1", 1, 479);
        send_frame(0, 256, 255, 1'b0);
        vsync_fall();
        check("short_next_swap", swap_cnt - s0, 1);
        check("short_next_front", int'(front_sel), 1);
        rd("short_next_rd200", 200, 200);

        // 5: long frame discarded after bin 255
        d0 = drop_cnt;
        s0 = swap_cnt;
        a0 = acc_cnt;
        w0 = wait_cycles;
        send_frame(1, 300, 299, 1'b0);
        step();
        check("long_drop", drop_cnt - d0, 1);
        check("long_drop_beat", drop_at - a0, 256);
        check("long_accepted", acc_cnt - a0, 300);
        check("long_no_stall", wait_cycles - w0, 0);
        vsync_fall();
        check("long_noswap", swap_cnt - s0, 0);
        check("long_front", int'(front_sel), 1);
        rd("long_rd200", 200, 200);
        send_frame(2, 256, 255, 1'b0);
        vsync_fall();
        check("long_next_swap", swap_cnt - s0, 1);
        check("long_next_front", int'(front_sel), 0);
        rd("long_next_rd7", 7, 1);

        // 6a: completing beat coincident with vsync fall
        s0 = swap_cnt;
        send_frame(0, 256, 255, 1'b1);
        repeat (3) step();
        check("coin_noswap", swap_cnt - s0, 0);
        check("coin_ready", int'(s_ready), 0);
        check("coin_front", int'(front_sel), 0);
        vsync = 1'b1;
        step();
        vsync_fall();
        check("coin_swap", swap_cnt - s0, 1);
        check("coin_front_after", int'(front_sel), 1);
        rd("coin_rd3", 3, 3);

        // 6b: reset mid-fill
        send_frame(1, 50, 999, 1'b0);
        rst_sync_n = 1'b0;
        #1;
        check("mid_rst_ready", int'(s_ready), 0);
        check("mid_rst_front", int'(front_sel), 0);
        check("mid_rst_rd", int'(rd_data), 0);
        step();
        rst_sync_n = 1'b1;
        step();
        check("mid_rel_ready", int'(s_ready), 1);
        rd("mid_rel_rd3", 3, 0);
        d0 = drop_cnt;
        s0 = swap_cnt;
        send_frame(0, 256, 255, 1'b0);
        check("mid_refill_ready", int'(s_ready), 0);
        vsync_fall();
        check("mid_refill_drop", drop_cnt - d0, 0);
        check("mid_refill_swap", swap_cnt - s0, 1);
        check("mid_refill_front", int'(front_sel), 1);
        rd("mid_refill_rd100", 100, 100);
        rd("mid_refill_rd255", 255, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
